// File: rtl/bsalu_pkg.sv
// bsalu_pkg: op encodings and controller state type shared by the bit-serial ALU
package bsalu_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_bit_cell.sv
// alu_bit_cell: combinational 1-bit logic unit, sel picks AND/OR/XOR/NOT x
module alu_bit_cell
  import bsalu_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic [1:0] sel,
  output logic       r
);
  assign r = sel == OP_AND ? x & y :
             sel == OP_OR  ? x | y :
             sel == OP_XOR ? x ^ y : ~x;
endmodule

// File: rtl/bitserial_alu_ctrl.sv
// bitserial_alu_ctrl: runs WIDTH-bit logic ops LSB-first through one 1-bit cell; BSALU_ZERO_FLAG_EN adds the zero output
module bitserial_alu_ctrl
  import bsalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef BSALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, res_d;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             r;
  logic             last;
`ifdef BSALU_ZERO_FLAG_EN
  logic             zero_q;
  assign zero = zero_q;
`endif
  alu_bit_cell u_cell (.x(sa_q[0]), .y(sb_q[0]), .sel(op_q), .r(r));
  assign res_d     = {r, res_q[WIDTH-1:1]};
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = res_q;
  // Sequencer: accept in IDLE, shift one bit per cycle in RUN, hold result in DONE until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      res_q   <= '0;
`ifdef BSALU_ZERO_FLAG_EN
      zero_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sa_q    <= a;
          sb_q    <= b;
          op_q    <= op;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q   <= res_d;
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          cnt_q   <= last ? cnt_q : cnt_q + CW'(1);
`ifdef BSALU_ZERO_FLAG_EN
          zero_q  <= res_d == '0;
`endif
          state_q <= last ? DONE : RUN;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// tb_bitserial_alu_ctrl: randomized and directed checks of the bit-serial ALU against a word-level model
module tb_bitserial_alu_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         busy;
`ifdef BSALU_ZERO_FLAG_EN
  logic         zero;
`endif
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  bitserial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
`ifdef BSALU_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Issue one request at the current negedge; stall = cycles of out_ready=0 in DONE, pulse_at = run cycle of an ignored in_valid pulse
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int stall, input int pulse_at);
    logic [W-1:0] e;
    int k;
    e = model(o, x, y);
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      in_valid = (k == pulse_at);
      if (k == pulse_at) begin op = 2'b01; a = '1; end
      @(negedge clk);
      k++;
      in_valid = 1'b0;
    end
    vectors++;
    if (k != W) begin errors++; $display("FAIL latency: got %0d want %0d", k, W); end
    vectors++;
    if (result !== e) begin errors++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", o, x, y, result, e); end
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL done_flags: busy=%b in_ready=%b want 1/0", busy, in_ready); end
`ifdef BSALU_ZERO_FLAG_EN
    vectors++;
    if (zero !== (e == '0)) begin errors++; $display("FAIL zero: got %b want %b", zero, e == '0); end
`endif
    for (int s = 0; s < stall; s++) begin
      vectors++;
      if (out_valid !== 1'b1 || result !== e || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold: out_valid=%b result=%h in_ready=%b want 1/%h/0", out_valid, result, in_ready, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== e) begin
      errors++; $display("FAIL release: out_valid=%b in_ready=%b busy=%b result=%h want 0/1/0/%h", out_valid, in_ready, busy, result, e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h want 1/0/0/00", in_ready, out_valid, busy, result);
    end
`ifdef BSALU_ZERO_FLAG_EN
    vectors++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_op(2'b00, 8'hCA, 8'h0F, 0, -1);
  endtask

  task automatic test_back_to_back;
    int t0;
    t0 = cyc;
    run_op(2'b01, 8'hCA, 8'h0F, 0, -1);
    run_op(2'b10, 8'hCA, 8'h0F, 0, -1);
    run_op(2'b11, 8'hCA, 8'h0F, 0, -1);
    vectors++;
    if (cyc - t0 != 3 * (W + 2)) begin errors++; $display("FAIL period: got %0d cycles want %0d", cyc - t0, 3 * (W + 2)); end
  endtask

  task automatic test_backpressure;
    run_op(2'b10, 8'h5A, 8'h3C, 3, -1);
  endtask

  task automatic test_ignore_in_run;
    run_op(2'b00, 8'hCA, 8'h0F, 0, 2);
  endtask

  task automatic test_mid_reset;
    in_valid = 1'b1; op = 2'b01; a = 8'h81; b = 8'h18;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: out_valid=%b busy=%b result=%h in_ready=%b want 0/0/00/1", out_valid, busy, result, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || result !== '0) begin errors++; $display("FAIL post_reset: in_ready=%b result=%h want 1/00", in_ready, result); end
    run_op(2'b10, 8'hF0, 8'h3C, 0, -1);
  endtask

  task automatic test_zero;
    run_op(2'b00, 8'hF0, 8'h0F, 0, -1);
    run_op(2'b01, 8'hF0, 8'h0F, 0, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run_op(2'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_ignore_in_run;
    test_mid_reset;
    test_zero;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bitserial_alu_ctrl.md
# bitserial_alu_ctrl

Sequencer that performs WIDTH-bit logic operations by driving a single 1-bit ALU cell one bit per clock, LSB first. Accepts an operation and two operands over a valid/ready handshake, iterates over all bit positions, and presents the assembled result over a second valid/ready handshake. It lets wide logic ops share one 1-bit ALU cell in area-constrained datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request carries a valid op/a/b
- in_ready  output  1  block can accept a request
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  assembled result
- busy  output  1  high in RUN or DONE
- zero  output  1  result == 0 (only with BSALU_ZERO_FLAG_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch op, a, b into shift registers, clear bit counter, go to RUN.
- RUN: each cycle, present sa[0], sb[0], op to the 1-bit cell. Shift the cell output into result from the MSB end. Shift sa/sb right by one. Increment the counter. When the counter reaches WIDTH-1, this cycle processes the final bit; go to DONE.
- DONE: out_valid=1 and result is stable. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored, because in_ready=0. Requests are never queued.
- op is sampled only at acceptance. Later changes on op/a/b have no effect.
- result holds its last value in IDLE. It changes only in RUN.
- Reset (async, any state): state IDLE, in_ready=1 in the first cycle after reset deassertion, out_valid=0, busy=0, result=0, counter=0, zero=1 (with macro). An in-flight operation is discarded.

## Timing
- Accepting edge = E0. RUN occupies the cycles after edges E0..E(WIDTH-1).
- out_valid rises after edge E(WIDTH). Latency from acceptance to out_valid is WIDTH cycles.
- Minimum request-to-request period is WIDTH+2 cycles: 1 accept, WIDTH run, 1 DONE with out_ready=1. The block returns to IDLE the edge after the output handshake.
- in_ready is a pure decode of state. It has no combinational path from out_ready.
- out_valid and result are registered. They have no combinational path from inputs.
- Counter width is clog2(WIDTH). There is no wrap-around beyond WIDTH-1.

## Configuration
- BSALU_ZERO_FLAG_EN defined: the `zero` output exists. It is registered and updated together with each result shift. It is valid whenever out_valid=1 and reflects the final result.
- Undefined: the `zero` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package bsalu_pkg holds:
  - op encoding constants: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11
  - state enum {IDLE, RUN, DONE}
- Sub-module alu_bit_cell: combinational 1-bit ALU (x, y, sel[1:0] -> r) using the op encoding above. It is instantiated once. The controller owns all sequencing and storage.

## Test plan
- WIDTH=8, op=AND, a=0xCA, b=0x0F, out_ready=1 -> out_valid 8 cycles after accept, result=0x0A, then in_ready returns.
- Back-to-back ops on 0xCA/0x0F: OR -> 0xCF, XOR -> 0xC5, NOT -> 0x35 (b ignored). Each completes in the minimum 10-cycle period.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and result stay constant, in_ready=0, then a single handshake.
- In RUN, pulse in_valid with a=0xFF, op=OR -> ignored; the first op's result is unchanged.
- Assert rst at RUN cycle 4 -> next cycle out_valid=0, busy=0, result=0, in_ready=1. A new op then runs correctly.
- With BSALU_ZERO_FLAG_EN: AND 0xF0, 0x0F -> result=0x00, zero=1. OR 0xF0, 0x0F -> 0xFF, zero=0.
